// File: rtl/time_setter.sv
// Button-driven time editor: captures the running time, lets hour/min/sec be stepped, then strobes time_ow.
// Optional macro TIME_SETTER_DEC_EN enables the btn_dec decrement path.
module time_setter #(
  parameter int OW_PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [16:0] time_cur,
  output logic [16:0] time_in,
  output logic        time_ow,
  output logic        editing,
  output logic [1:0]  field_sel
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    OW_LAST = 8'(OW_PULSE_CYCLES);

  typedef enum logic [2:0] {IDLE, SET_HR, SET_MIN, SET_SEC, COMMIT} state_t;

`ifdef TIME_SETTER_DEC_EN
  localparam int NB = 3;
  logic [NB-1:0] btn_now;
  assign btn_now = {btn_dec, btn_inc, btn_mode};
`else
  localparam int NB = 2;
  logic [NB-1:0] btn_now;
  logic          unused_btn_dec;
  assign btn_now        = {btn_inc, btn_mode};
  assign unused_btn_dec = btn_dec;
`endif

  state_t        state_reg, state_next;
  logic [NB-1:0] btn_prev_reg;
  logic          armed_reg;
  logic [NB-1:0] edge_vec;
  logic [4:0]    hr_reg, hr_next;
  logic [5:0]    min_reg, min_next, sec_reg, sec_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [7:0]    ow_cnt_reg, ow_cnt_next;
  logic          time_ow_reg, time_ow_next;
  logic          editing_reg, editing_next;
  logic [1:0]    field_sel_reg, field_sel_next;
  logic          mode_edge, inc_step, dec_step, activity, in_set;

  // armed_reg masks the first cycle after reset so a held button is not seen as an edge
  for (genvar gi = 0; gi < NB; gi++) begin : g_edge
    assign edge_vec[gi] = armed_reg & btn_now[gi] & ~btn_prev_reg[gi];
  end

  assign mode_edge = edge_vec[0];
  assign activity  = |edge_vec;
`ifdef TIME_SETTER_DEC_EN
  assign inc_step = edge_vec[1] & ~edge_vec[2] & ~mode_edge;
  assign dec_step = edge_vec[2] & ~edge_vec[1] & ~mode_edge;
`else
  assign inc_step = edge_vec[1] & ~mode_edge;
  assign dec_step = 1'b0;
`endif

  assign in_set = (state_reg == SET_HR) || (state_reg == SET_MIN) || (state_reg == SET_SEC);

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] top,
                                            input logic up, input logic down);
    if (up)   return (v == top)  ? 6'd0 : v + 6'd1;
    if (down) return (v == 6'd0) ? top  : v - 6'd1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      btn_prev_reg  <= '0;
      armed_reg     <= 1'b0;
      hr_reg        <= '0;
      min_reg       <= '0;
      sec_reg       <= '0;
      to_cnt_reg    <= '0;
      ow_cnt_reg    <= '0;
      time_ow_reg   <= 1'b0;
      editing_reg   <= 1'b0;
      field_sel_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      btn_prev_reg  <= btn_now;
      armed_reg     <= 1'b1;
      hr_reg        <= hr_next;
      min_reg       <= min_next;
      sec_reg       <= sec_next;
      to_cnt_reg    <= to_cnt_next;
      ow_cnt_reg    <= ow_cnt_next;
      time_ow_reg   <= time_ow_next;
      editing_reg   <= editing_next;
      field_sel_reg <= field_sel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mode_edge) state_next = SET_HR;
      SET_HR:  if (mode_edge) state_next = SET_MIN;
               else if (!activity && to_cnt_reg == TO_LAST) state_next = IDLE;
      SET_MIN: if (mode_edge) state_next = SET_SEC;
               else if (!activity && to_cnt_reg == TO_LAST) state_next = IDLE;
      SET_SEC: if (mode_edge) state_next = COMMIT;
               else if (!activity && to_cnt_reg == TO_LAST) state_next = IDLE;
      COMMIT:  if (ow_cnt_reg == OW_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hr_next     = hr_reg;
    min_next    = min_reg;
    sec_next    = sec_reg;
    to_cnt_next = '0;
    ow_cnt_next = '0;
    case (state_reg)
      IDLE: if (mode_edge) begin
        // out-of-range fields from the running clock are replaced by zero
        hr_next  = (time_cur[16:12] > 5'd23) ? 5'd0 : time_cur[16:12];
        min_next = (time_cur[11:6]  > 6'd59) ? 6'd0 : time_cur[11:6];
        sec_next = (time_cur[5:0]   > 6'd59) ? 6'd0 : time_cur[5:0];
      end
      SET_HR:  hr_next  = 5'(step_field({1'b0, hr_reg}, 6'd23, inc_step, dec_step));
      SET_MIN: min_next = step_field(min_reg, 6'd59, inc_step, dec_step);
      SET_SEC: sec_next = step_field(sec_reg, 6'd59, inc_step, dec_step);
      COMMIT:  if (state_next == COMMIT) ow_cnt_next = ow_cnt_reg + 8'd1;
      default: ;
    endcase
    if (in_set && !activity && state_next != IDLE) to_cnt_next = to_cnt_reg + 1'b1;

    editing_next = (state_next != IDLE);
    time_ow_next = (state_reg == COMMIT) && (state_next == COMMIT);
    case (state_next)
      SET_HR:  field_sel_next = 2'd1;
      SET_MIN: field_sel_next = 2'd2;
      SET_SEC: field_sel_next = 2'd3;
      default: field_sel_next = 2'd0;
    endcase
  end

  assign time_in   = {hr_reg, min_reg, sec_reg};
  assign time_ow   = time_ow_reg;
  assign editing   = editing_reg;
  assign field_sel = field_sel_reg;

endmodule
